// File: rtl/butterfly_result_serializer_pkg.sv
// Shared definitions for the butterfly harness serializers: FSM states,
// result-word ordering and the word-index width helper.
package butterfly_result_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Word positions inside a packed result message, word 0 sent first.
  localparam int WORD_CR = 0;
  localparam int WORD_CC = 1;
  localparam int WORD_DR = 2;
  localparam int WORD_DC = 3;
  localparam int RESULT_WORDS = 4;

  // Index width for a frame of 'words' entries; never narrower than 1 bit.
  function automatic int idx_width(input int words);
    int w;
    w = 1;
    while ((32'sd1 << w) < words) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/butterfly_result_serializer_if.sv
// Wide-message receive channel plus narrow-word send channel.
interface butterfly_result_serializer_if
  import butterfly_result_serializer_pkg::*;
#(
  parameter int n = 32,
  parameter int m = RESULT_WORDS
) ();

  logic             recv_val;
  logic             recv_rdy;
  logic [m*n-1:0]   recv_msg;
  logic             send_val;
  logic             send_rdy;
  logic [n-1:0]     send_msg;
  logic             send_last;

  // Environment side: offers wide messages, consumes words.
  modport master (
    output recv_val,
    output recv_msg,
    input  recv_rdy,
    input  send_val,
    input  send_msg,
    input  send_last,
    output send_rdy
  );

  // Serializer side.
  modport slave (
    input  recv_val,
    input  recv_msg,
    output recv_rdy,
    output send_val,
    output send_msg,
    output send_last,
    input  send_rdy
  );

endinterface

// File: rtl/butterfly_result_serializer.sv
// Splits one packed m-word result message into an n-bit word stream, MS word
// first, with a last-word flag and zero-bubble hand-over between frames.
module butterfly_result_serializer
  import butterfly_result_serializer_pkg::*;
#(
  parameter int n = 32,
  parameter int m = RESULT_WORDS
) (
  input  logic                          clk,
  input  logic                          reset,
  butterfly_result_serializer_if.slave  bus
);

  localparam int            IW       = idx_width(m);
  localparam logic [IW-1:0] LAST_IDX = IW'(m - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [m*n-1:0]  buf_q, buf_d;
  logic [n-1:0]    words_s [m];
  logic            send_val_s;
  logic            send_last_s;
  logic            send_fire_s;
  logic            last_s;
  logic            recv_rdy_s;
  logic            recv_fire_s;

  // View the holding register as an array with word 0 at the top slice.
  always_comb begin
    for (int k = 0; k < m; k++) begin
      words_s[k] = buf_q[(m - 1 - k) * n +: n];
    end
  end

  // Handshake decode; recv_rdy is the only path fed by an input (send_rdy).
  always_comb begin
    send_val_s  = (state_q == ST_SEND);
    last_s      = (idx_q == LAST_IDX);
    send_last_s = send_val_s && last_s;
    send_fire_s = send_val_s && bus.send_rdy;
    recv_rdy_s  = (state_q == ST_IDLE) || (send_fire_s && last_s);
    recv_fire_s = bus.recv_val && recv_rdy_s;
  end

  assign bus.send_val  = send_val_s;
  assign bus.send_last = send_last_s;
  assign bus.send_msg  = words_s[idx_q];
  assign bus.recv_rdy  = recv_rdy_s;

  // Next-state: load on accept, advance on each sent word, reload on the last.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (recv_fire_s) begin
          buf_d   = bus.recv_msg;
          idx_d   = {IW{1'b0}};
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (send_fire_s) begin
          if (!last_s) begin
            idx_d = idx_q + IW'(1);
          end else if (recv_fire_s) begin
            buf_d   = bus.recv_msg;
            idx_d   = {IW{1'b0}};
            state_d = ST_SEND;
          end else begin
            idx_d   = {IW{1'b0}};
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // State, index and holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= {IW{1'b0}};
      buf_q   <= {(m * n){1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_butterfly_result_serializer.sv
// Self-checking bench: directed frames with literal expectations plus a
// randomized val/rdy run checked against a word-queue reference model.
module tb_butterfly_result_serializer;
  import butterfly_result_serializer_pkg::*;

  localparam int N = 32;
  localparam int M = 4;

  logic clk;
  logic reset;

  butterfly_result_serializer_if #(.n(N), .m(M)) bus ();

  butterfly_result_serializer #(.n(N), .m(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors;
  int errors;

  // Reference model: remaining words of the frame in flight and their last flags.
  logic [N-1:0] exp_w [$];
  bit           exp_l [$];
  bit           m_busy;
  bit           m_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare against the model on the falling edge, then advance the model
  // with the transfers the coming rising edge will perform.
  always @(negedge clk) begin
    if (reset) begin
      exp_w.delete();
      exp_l.delete();
      check("rst_send_val", {31'd0, bus.send_val}, 32'd0);
      check("rst_send_last", {31'd0, bus.send_last}, 32'd0);
      check("rst_send_msg", bus.send_msg, 32'd0);
    end else begin
      m_busy = (exp_w.size() > 0);
      m_rdy  = !m_busy || (exp_w.size() == 1 && bus.send_rdy);
      check("send_val", {31'd0, bus.send_val}, {31'd0, m_busy});
      check("recv_rdy", {31'd0, bus.recv_rdy}, {31'd0, m_rdy});
      if (m_busy) begin
        check("send_msg", bus.send_msg, exp_w[0]);
        check("send_last", {31'd0, bus.send_last}, {31'd0, exp_l[0]});
        if (bus.send_rdy) begin
          void'(exp_w.pop_front());
          void'(exp_l.pop_front());
        end
      end
      if (bus.recv_val && m_rdy) begin
        for (int k = 0; k < M; k++) begin
          exp_w.push_back(bus.recv_msg[(M - 1 - k) * N +: N]);
          exp_l.push_back(k == M - 1);
        end
      end
    end
  end

  logic [N-1:0] lit [8];
  bit           took;
  int           rand_frames;
  int           cyc;

  initial begin
    vectors     = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.recv_val = 1'b0;
    bus.recv_msg = '0;
    bus.send_rdy = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("post_reset_recv_rdy", {31'd0, bus.recv_rdy}, 32'd1);
    check("post_reset_send_val", {31'd0, bus.send_val}, 32'd0);

    // Single frame.
    bus.recv_msg = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bus.recv_val = 1'b1;
    bus.send_rdy = 1'b1;
    lit[0] = 32'h11111111; lit[1] = 32'h22222222;
    lit[2] = 32'h33333333; lit[3] = 32'h44444444;
    step();
    bus.recv_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_msg", bus.send_msg, lit[k]);
      check("single_last", {31'd0, bus.send_last}, (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    check("single_idle_val", {31'd0, bus.send_val}, 32'd0);
    check("single_idle_rdy", {31'd0, bus.recv_rdy}, 32'd1);

    // Back-to-back frames with recv_val held high.
    bus.recv_msg = {32'd1, 32'd2, 32'd3, 32'd4};
    bus.recv_val = 1'b1;
    step();
    bus.recv_msg = {32'd5, 32'd6, 32'd7, 32'd8};
    for (int k = 0; k < 8; k++) begin
      check("b2b_val", {31'd0, bus.send_val}, 32'd1);
      check("b2b_msg", bus.send_msg, 32'(k + 1));
      check("b2b_last", {31'd0, bus.send_last}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
      if (k == 1) check("b2b_busy_rdy", {31'd0, bus.recv_rdy}, 32'd0);
      if (k == 3) check("b2b_handover_rdy", {31'd0, bus.recv_rdy}, 32'd1);
      step();
      if (k == 3) bus.recv_val = 1'b0;
    end
    check("b2b_idle", {31'd0, bus.send_val}, 32'd0);

    // Backpressure on the second word.
    bus.recv_msg = {32'hA, 32'hB, 32'hC, 32'hD};
    bus.recv_val = 1'b1;
    step();
    bus.recv_val = 1'b0;
    step();
    bus.send_rdy = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_msg", bus.send_msg, 32'hB);
      check("bp_hold_val", {31'd0, bus.send_val}, 32'd1);
      check("bp_hold_rdy", {31'd0, bus.recv_rdy}, 32'd0);
      step();
    end
    bus.send_rdy = 1'b1;
    #1;
    check("bp_resume_b", bus.send_msg, 32'hB);
    step();
    check("bp_resume_c", bus.send_msg, 32'hC);
    step();
    check("bp_resume_d", bus.send_msg, 32'hD);
    check("bp_last", {31'd0, bus.send_last}, 32'd1);
    step();

    // Busy rejection: new message offered while word 1 is sent.
    bus.recv_msg = {32'h21, 32'h22, 32'h23, 32'h24};
    bus.recv_val = 1'b1;
    step();
    bus.recv_msg = {32'h31, 32'h32, 32'h33, 32'h34};
    step();
    check("busy_rdy", {31'd0, bus.recv_rdy}, 32'd0);
    check("busy_msg", bus.send_msg, 32'h22);
    step();
    check("busy_keep", bus.send_msg, 32'h23);
    step();
    check("busy_last_rdy", {31'd0, bus.recv_rdy}, 32'd1);
    step();
    bus.recv_val = 1'b0;
    check("busy_next_first", bus.send_msg, 32'h31);
    repeat (4) step();

    // Reset in the middle of a frame.
    bus.recv_msg = {32'h51, 32'h52, 32'h53, 32'h54};
    bus.recv_val = 1'b1;
    step();
    bus.recv_val = 1'b0;
    step();
    step();
    check("pre_reset_msg", bus.send_msg, 32'h53);
    #1 reset = 1'b1;
    #1;
    check("async_reset_val", {31'd0, bus.send_val}, 32'd0);
    check("async_reset_msg", bus.send_msg, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("after_reset_rdy", {31'd0, bus.recv_rdy}, 32'd1);
    bus.recv_msg = {32'd9, 32'd10, 32'd11, 32'd12};
    bus.recv_val = 1'b1;
    step();
    bus.recv_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("post_reset_frame", bus.send_msg, 32'(9 + k));
      step();
    end

    // Randomized val/rdy; upstream holds its message until accepted.
    rand_frames = 0;
    cyc = 0;
    while (rand_frames < 1000 && cyc < 30000) begin
      @(negedge clk);
      took = bus.recv_val && bus.recv_rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (took) rand_frames++;
      if (took || !bus.recv_val) begin
        bus.recv_val = ($urandom_range(0, 3) != 0);
        bus.recv_msg = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.send_rdy = ($urandom_range(0, 4) != 0);
    end
    if (rand_frames < 1000) begin
      vectors++;
      errors++;
      $display("FAIL random_budget: got %0d frames expected 1000", rand_frames);
    end

    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b1;
    cyc = 0;
    while (bus.send_val && cyc < 50) begin
      step();
      cyc++;
    end
    @(negedge clk);
    #1;
    check("drain_idle", {31'd0, bus.send_val}, 32'd0);
    check("model_empty", 32'(exp_w.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
